// File: rtl/snes_pad_responder.sv
// snes_pad_responder: SNES pad-side serial responder; latches a 12-button snapshot and shifts it out active-low.
//   buttons    : 12-bit button word, 1 = pressed, bit 0 = B
//   snes_latch : console latch (async), snes_clk : console serial clock (async, idles high)
//   snes_data  : registered serial data, active-low
//   busy       : high in LATCH/SHIFT, frame_done : one-cycle pulse on DONE entry
module snes_pad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int N_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] buttons,
  input  logic        snes_latch,
  input  logic        snes_clk,
  output logic        snes_data,
  output logic        busy,
  output logic        frame_done
);
  localparam int CW = $clog2(N_BITS + 1);
  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] lat_sync_q, sclk_sync_q;
  logic lat_prev_q, sclk_prev_q, lat_s, sclk_s, lat_fall, sclk_rise;
  logic [N_BITS-1:0] shreg_q, shreg_d, frame;
  logic [CW-1:0] cnt_q, cnt_d;
  logic data_q, data_d, done_q, done_d;
  assign lat_s = lat_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign lat_fall = lat_prev_q & ~lat_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_sync_q <= '0;
      sclk_sync_q <= '1;
      lat_prev_q <= 1'b0;
      sclk_prev_q <= 1'b1;
      state_q <= IDLE;
      shreg_q <= '1;
      cnt_q <= '0;
      data_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], snes_latch};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], snes_clk};
      lat_prev_q <= lat_s;
      sclk_prev_q <= sclk_s;
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end
  // Latch has priority over everything, so a rising latch beats any clock edge
  // and a falling latch consumes a coincident clock edge without counting it.
  always_comb begin
    frame = '1;
    frame[11:0] = ~buttons;
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (lat_s) begin
      state_d = LATCH;
      shreg_d = frame;
    end else if (state_q == LATCH && lat_fall) begin
      state_d = SHIFT;
      cnt_d = '0;
    end else if (state_q == SHIFT && sclk_rise) begin
      shreg_d = {1'b1, shreg_q[N_BITS-1:1]};
      cnt_d = (cnt_q == CW'(N_BITS)) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d == CW'(N_BITS)) begin
        state_d = DONE;
        done_d = 1'b1;
      end
    end
    // Data is registered from the next state so it moves together with the FSM.
    data_d = (state_d == IDLE) ? 1'b1 : (state_d == DONE) ? 1'b0 : shreg_d[0];
  end
  assign snes_data = data_q;
  assign busy = (state_q == LATCH) || (state_q == SHIFT);
  assign frame_done = done_q;
endmodule
